// File: rtl/fp_seq_multiplier_pkg.sv
// Shared definitions for the sequential single-precision multiplier:
// FSM encoding, IEEE-754 constants and significand width.
package fp_seq_multiplier_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UNPACK,
    ST_MUL,
    ST_NORM,
    ST_ROUND,
    ST_DONE
  } state_t;

  localparam int          EXP_BIAS = 127;
  localparam int          SIG_W    = 24;
  localparam logic [31:0] QNAN     = 32'h7FC0_0000;
  localparam logic [31:0] INF_MAG  = 32'h7F80_0000;

endpackage

// File: rtl/fp_unpack_classify.sv
// Combinational IEEE-754 single unpacker: splits an operand into fields and
// classifies it; denormals are flushed to zero.
module fp_unpack_classify
  import fp_seq_multiplier_pkg::*;
(
  input  logic [31:0]      i_op,
  output logic             o_sign,
  output logic [7:0]       o_exp,
  output logic [SIG_W-1:0] o_sig,
  output logic             o_is_zero,
  output logic             o_is_inf,
  output logic             o_is_nan
);

  logic w_exp_max;
  logic w_frac_nz;

  assign w_exp_max = (i_op[30:23] == 8'hFF);
  assign w_frac_nz = (i_op[22:0] != 23'd0);

  assign o_sign    = i_op[31];
  assign o_exp     = i_op[30:23];
  assign o_is_zero = (i_op[30:23] == 8'h00);
  assign o_is_inf  = w_exp_max & ~w_frac_nz;
  assign o_is_nan  = w_exp_max & w_frac_nz;
  assign o_sig     = o_is_zero ? '0 : {1'b1, i_op[22:0]};

endmodule

// File: rtl/fp_seq_multiplier.sv
// Sequential IEEE-754 single multiplier, radix-2 shift-add over 24 cycles.
// Define FP_MUL_RNE_EN for round-to-nearest-even; otherwise truncation.
//
// state  | meaning
// IDLE   | waiting for start, operands latched on request
// UNPACK | classify operands, resolve specials, seed product register
// MUL    | one shift-add iteration per cycle, 24 total
// NORM   | biased exponent, align product so hidden bit sits at bit 46
// ROUND  | round, range check, load s
// DONE   | finish high until start drops
module fp_seq_multiplier
  import fp_seq_multiplier_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] s,
  output logic        finish,
  output logic        busy
);

  state_t r_state, w_next;

  logic [31:0]       r_a, r_b, r_s;
  logic [47:0]       r_prod;
  logic [4:0]        r_cnt;
  logic signed [9:0] r_exp;
  logic              r_finish;

  logic             w_sign_a, w_sign_b, w_zero_a, w_zero_b;
  logic             w_inf_a, w_inf_b, w_nan_a, w_nan_b;
  logic [7:0]       w_exp_a, w_exp_b;
  logic [SIG_W-1:0] w_sig_a, w_sig_b;

  fp_unpack_classify u_unpack_a (
    .i_op(r_a), .o_sign(w_sign_a), .o_exp(w_exp_a), .o_sig(w_sig_a),
    .o_is_zero(w_zero_a), .o_is_inf(w_inf_a), .o_is_nan(w_nan_a)
  );

  fp_unpack_classify u_unpack_b (
    .i_op(r_b), .o_sign(w_sign_b), .o_exp(w_exp_b), .o_sig(w_sig_b),
    .o_is_zero(w_zero_b), .o_is_inf(w_inf_b), .o_is_nan(w_nan_b)
  );

  logic        w_sign;
  logic        w_special;
  logic [31:0] w_special_val;

  assign w_sign = w_sign_a ^ w_sign_b;

  always_comb begin
    w_special     = 1'b1;
    w_special_val = QNAN;
    if (w_nan_a | w_nan_b | (w_inf_a & w_zero_b) | (w_zero_a & w_inf_b)) begin
      w_special_val = QNAN;
    end else if (w_inf_a | w_inf_b) begin
      w_special_val = {w_sign, 31'd0} | INF_MAG;
    end else if (w_zero_a | w_zero_b) begin
      w_special_val = {w_sign, 31'd0};
    end else begin
      w_special = 1'b0;
    end
  end

  // Upper half accumulates the multiplicand; carry rides into bit 47 on the shift.
  logic [24:0] w_add;
  logic [47:0] w_prod_step;

  assign w_add       = {1'b0, r_prod[47:24]} + {1'b0, w_sig_a};
  assign w_prod_step = r_prod[0] ? {w_add, r_prod[23:1]} : {1'b0, r_prod[47:1]};

  logic signed [9:0] w_exp_sum;

  assign w_exp_sum = 10'({2'b00, w_exp_a} + {2'b00, w_exp_b} - 10'(EXP_BIAS));

  logic              w_round_up;
  logic [24:0]       w_mant;
  logic [22:0]       w_frac_rnd;
  logic signed [9:0] w_exp_rnd;
  logic [31:0]       w_round_val;

`ifdef FP_MUL_RNE_EN
  // guard = bit 22, round|sticky = bits 21:0, lsb = bit 23
  assign w_round_up = r_prod[22] & ((|r_prod[21:0]) | r_prod[23]);
`else
  assign w_round_up = 1'b0;
`endif

  assign w_mant     = {1'b0, r_prod[46:23]} + 25'(w_round_up);
  assign w_frac_rnd = w_mant[24] ? w_mant[23:1] : w_mant[22:0];
  assign w_exp_rnd  = r_exp + 10'(w_mant[24]);

  always_comb begin
    w_round_val = {w_sign, w_exp_rnd[7:0], w_frac_rnd};
    if (w_exp_rnd >= 10'sd255) begin
      w_round_val = {w_sign, 31'd0} | INF_MAG;
    end else if (w_exp_rnd <= 10'sd0) begin
      w_round_val = {w_sign, 31'd0};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b1;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) w_next = ST_UNPACK;
      end
      ST_UNPACK: w_next = w_special ? ST_DONE : ST_MUL;
      ST_MUL:    if (r_cnt == 5'd0) w_next = ST_NORM;
      ST_NORM:   w_next = ST_ROUND;
      ST_ROUND:  w_next = ST_DONE;
      ST_DONE:   if (r_finish && !start) w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_a      <= '0;
      r_b      <= '0;
      r_s      <= '0;
      r_prod   <= '0;
      r_cnt    <= '0;
      r_exp    <= '0;
      r_finish <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_a <= a;
            r_b <= b;
          end
        end
        ST_UNPACK: begin
          if (w_special) begin
            r_s <= w_special_val;
          end else begin
            r_prod <= {24'd0, w_sig_b};
            r_cnt  <= 5'(SIG_W - 1);
          end
        end
        ST_MUL: begin
          r_prod <= w_prod_step;
          if (r_cnt != 5'd0) r_cnt <= r_cnt - 5'd1;
        end
        ST_NORM: begin
          // Bit shifted out is folded into bit 0 so sticky still sees it.
          if (r_prod[47]) begin
            r_prod <= {1'b0, r_prod[47:2], r_prod[1] | r_prod[0]};
            r_exp  <= w_exp_sum + 10'sd1;
          end else begin
            r_exp  <= w_exp_sum;
          end
        end
        ST_ROUND: begin
          r_s      <= w_round_val;
          r_finish <= 1'b1;
        end
        ST_DONE: begin
          // Special results arrive here with finish still low; raise it first.
          if (!r_finish)   r_finish <= 1'b1;
          else if (!start) r_finish <= 1'b0;
        end
        default: r_finish <= 1'b0;
      endcase
    end
  end

  assign s      = r_s;
  assign finish = r_finish;

endmodule
